pwr_seq: RTL

Power-rail sequencer for the PHOS FEC board. It sits directly downstream of the DTC command register block and consumes its `reg_pwr_en` word. It drives every switchable `ON_*` rail enable in a fixed per-domain order, gated by the board `PGOOD_*` returns, with per-stage timeouts and latched faults. Status and fault bits are returned to the command register block for DTC readback.

---
 rtl/pwr_seq_if.sv | 22 ++
 rtl/pwr_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwr_seq_if.sv
// pwr_seq_if: command-register side of the rail sequencer.
// Enables and fault clear in, status and fault back out.
interface pwr_seq_if;
  logic [15:0] reg_pwr_en;
  logic        fault_clr;
  logic [15:0] pwr_status;
  logic        pwr_fault;

  modport master (
    output reg_pwr_en,
    output fault_clr,
    input  pwr_status,
    input  pwr_fault
  );

  modport slave (
    input  reg_pwr_en,
    input  fault_clr,
    output pwr_status,
    output pwr_fault
  );
endinterface

// File: rtl/pwr_seq.sv
// pwr_seq: PHOS FEC power-rail sequencer, five domain FSMs
// with PGOOD gating, stage timeouts and latched faults.
module pwr_seq #(
  parameter int SETTLE_CYCLES = 40000,
  parameter int PGOOD_TIMEOUT = 400000
) (
  input  logic dtc_clk,
  input  logic rst_n,
  pwr_seq_if.slave bus,
  input  logic pgood_1v8a_adc,
  input  logic pgood_1v8d_adc,
  input  logic pgood_1v2d_adc,
  input  logic pgood_3v3_shaper,
  input  logic pgood_3v3_tdc,
  output logic on_1v8a_adc,
  output logic on_1v8d_adc,
  output logic on_1v2d_adc,
  output logic on_3v3_shaper,
  output logic on_5v0_sum,
  output logic on_3v3_tdc,
  output logic on_2v5_tdc,
  output logic on_12v5,
  output logic on_n5v0,
  output logic on_5v0_bias
);

  localparam int TMAX =
    (SETTLE_CYCLES > PGOOD_TIMEOUT) ?
    SETTLE_CYCLES : PGOOD_TIMEOUT;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_TO =
    TW'(PGOOD_TIMEOUT - 1);
  localparam logic [TW-1:0] T_ST =
    TW'(SETTLE_CYCLES - 1);

  localparam logic [2:0] OFF       = 3'd0;
  localparam logic [2:0] S1_WAIT   = 3'd1;
  localparam logic [2:0] S1_SETTLE = 3'd2;
  localparam logic [2:0] S2_WAIT   = 3'd3;
  localparam logic [2:0] S2_SETTLE = 3'd4;
  localparam logic [2:0] ON        = 3'd5;
  localparam logic [2:0] FAULT     = 3'd6;

  // domain index: 0 adc, 1 shaper, 2 tdc, 3 strip, 4 bias
  localparam logic [4:0] HAS_S2 = 5'b00101;

  // Faults are checked before the enable so that a
  // coincident enable drop still latches the fault.
  function automatic logic [2:0] step(
    input logic [2:0]    cs,
    input logic          e,
    input logic          g,
    input logic          h,
    input logic          p1,
    input logic          p2,
    input logic          two,
    input logic          c,
    input logic [TW-1:0] t
  );
    logic [2:0] n;
    n = cs;
    case (cs)
      OFF:
        if (e && g) n = S1_WAIT;
      S1_WAIT:
        if (!p1 && t == T_TO) n = FAULT;
        else if (!e || !h)    n = OFF;
        else if (p1)          n = S1_SETTLE;
      S1_SETTLE:
        if (!p1)              n = FAULT;
        else if (!e || !h)    n = OFF;
        else if (t == T_ST)   n = two ? S2_WAIT : ON;
      S2_WAIT:
        if (!p1)              n = FAULT;
        else if (!p2 && t == T_TO)
                              n = FAULT;
        else if (!e || !h)    n = OFF;
        else if (p2)          n = S2_SETTLE;
      S2_SETTLE:
        if (!p1 || !p2)       n = FAULT;
        else if (!e || !h)    n = OFF;
        else if (t == T_ST)   n = ON;
      ON:
        if (!p1 || (two && !p2))
                              n = FAULT;
        else if (!e || !h)    n = OFF;
      FAULT:
        if (c) n = OFF;
      default:
        n = OFF;
    endcase
    return n;
  endfunction

  logic [4:0] pg_raw;
  logic [4:0] pg_m;
  logic [4:0] pg_s;
  logic [4:0] en;
  logic [4:0] pg1;
  logic [4:0] pg2;
  logic       unused_en;

  assign pg_raw = {pgood_3v3_tdc, pgood_3v3_shaper,
                   pgood_1v2d_adc, pgood_1v8d_adc,
                   pgood_1v8a_adc};

  assign en = {bus.reg_pwr_en[5:2],
               bus.reg_pwr_en[0]};
  assign unused_en = ^{bus.reg_pwr_en[15:6],
                       bus.reg_pwr_en[1]};

  assign pg1 = {2'b11, pg_s[4], pg_s[3],
                pg_s[0] & pg_s[1]};
  assign pg2 = {4'b1111, pg_s[2]};

  // Two-flop synchronizers for the board PGOOD inputs
  always_ff @(posedge dtc_clk or negedge rst_n) begin
    if (!rst_n) begin
      pg_m <= '0;
      pg_s <= '0;
    end else begin
      pg_m <= pg_raw;
      pg_s <= pg_m;
    end
  end

  logic [2:0]    st  [5];
  logic [2:0]    nx  [5];
  logic [TW-1:0] tmr [5];
  logic          go_b;
  logic          hold_b;

  // Next state; bias tracks where shaper/strip are heading
  always_comb begin
    for (int d = 0; d < 4; d++) begin
      nx[d] = step(st[d], en[d], 1'b1, 1'b1,
                   pg1[d], pg2[d], HAS_S2[d],
                   bus.fault_clr, tmr[d]);
    end
    go_b   = (st[1] == ON) && (st[3] == ON);
    hold_b = (nx[1] == ON) && (nx[3] == ON);
    nx[4]  = step(st[4], en[4], go_b, hold_b,
                  pg1[4], pg2[4], HAS_S2[4],
                  bus.fault_clr, tmr[4]);
  end

  // State and per-domain timers, cleared on state entry
  always_ff @(posedge dtc_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 5; d++) begin
        st[d]  <= OFF;
        tmr[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 5; d++) begin
        st[d] <= nx[d];
        if (nx[d] != st[d])
          tmr[d] <= '0;
        else if (tmr[d] != '1)
          tmr[d] <= tmr[d] + 1'b1;
      end
    end
  end

  logic [4:0] s1_d;
  logic [4:0] s2_d;
  logic [4:0] on_d;
  logic [4:0] flt_d;

  // Rail and status decode from next state
  always_comb begin
    s1_d  = '0;
    s2_d  = '0;
    on_d  = '0;
    flt_d = '0;
    for (int d = 0; d < 5; d++) begin
      s1_d[d]  = (nx[d] != OFF) && (nx[d] != FAULT);
      s2_d[d]  = nx[d] inside
                 {S2_WAIT, S2_SETTLE, ON};
      on_d[d]  = (nx[d] == ON);
      flt_d[d] = (nx[d] == FAULT);
    end
  end

  logic [4:0] s1_q;
  logic [4:0] s2_q;
  logic [4:0] on_q;
  logic [4:0] flt_q;
  logic       fault_q;

  // Registered outputs
  always_ff @(posedge dtc_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      on_q    <= '0;
      flt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d & HAS_S2;
      on_q    <= on_d;
      flt_q   <= flt_d;
      fault_q <= |flt_d;
    end
  end

  assign on_1v8a_adc   = s1_q[0];
  assign on_1v8d_adc   = s1_q[0];
  assign on_1v2d_adc   = s2_q[0];
  assign on_3v3_shaper = s1_q[1];
  assign on_5v0_sum    = s1_q[1];
  assign on_3v3_tdc    = s1_q[2];
  assign on_2v5_tdc    = s2_q[2];
  assign on_12v5       = s1_q[3];
  assign on_n5v0       = s1_q[3];
  assign on_5v0_bias   = s1_q[4];

  assign bus.pwr_status = {2'b00, flt_q[4:1],
                           1'b0, flt_q[0],
                           2'b00, on_q[4:1],
                           1'b0, on_q[0]};
  assign bus.pwr_fault  = fault_q;

endmodule
